tow_match_ctrl: RTL and testbench

- Match sequencer and input arbiter that sits between the raw player buttons and the tug-of-war game datapath.
- Synchronizes and edge-detects both player keys, then grants at most one press pulse per cycle to the game with round-robin tie-breaking.
- Tracks round wins and holds the game in reset between rounds.
- Declares the match winner on the first player to reach WINS_TO_MATCH rounds.

---
 rtl/tow_match_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_tow_match_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tow_match_ctrl.sv
// -----------------------------------------------------------------------------
// tow_match_ctrl
//   Match sequencer and press arbiter between the raw player buttons and the
//   tug-of-war game datapath. Synchronizes and edge-detects both keys, grants
//   at most one press pulse per cycle (round-robin on ties), counts round wins,
//   holds the game in reset between rounds and declares the match winner.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; game held in reset, scores zero
//   PLAY  | round in progress; presses arbitrated to the game
//   PAUSE | between rounds; game held in reset for PAUSE_CYCLES cycles
//   OVER  | match decided; final playfield shown until start drops
//
// Ports
//   clk          game clock
//   reset        asynchronous active-low reset
//   key0_n       raw player-0 button, active-low, asynchronous
//   key1_n       raw player-1 button, active-low, asynchronous
//   start        1 = begin match, 0 = return to idle once the match is over
//   win_valid    one-cycle pulse from game: a round was won
//   win_player   winner of that round
//   press0       one-cycle press pulse to game, player 0
//   press1       one-cycle press pulse to game, player 1
//   game_reset   active-high synchronous reset to the game datapath
//   score0       player-0 rounds won
//   score1       player-1 rounds won
//   match_over   high while in OVER
//   match_winner winner of the match, meaningful with match_over
//   state        current state (IDLE=00, PLAY=01, PAUSE=10, OVER=11)
// -----------------------------------------------------------------------------
module tow_match_ctrl #(
    parameter int WINS_TO_MATCH = 3,
    parameter int PAUSE_CYCLES  = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key0_n,
    input  logic       key1_n,
    input  logic       start,
    input  logic       win_valid,
    input  logic       win_player,
    output logic       press0,
    output logic       press1,
    output logic       game_reset,
    output logic [3:0] score0,
    output logic [3:0] score1,
    output logic       match_over,
    output logic       match_winner,
    output logic [1:0] state
);

    localparam int            CW         = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
    localparam logic [CW-1:0] PAUSE_LOAD = CW'(PAUSE_CYCLES - 1);
    localparam logic [3:0]    WINS       = 4'(WINS_TO_MATCH);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PLAY  = 2'b01,
        PAUSE = 2'b10,
        OVER  = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync0, sync1;      // [0] first flop, [1] second flop
    logic [1:0]    prev;              // previous synchronized pressed, per player
    logic [1:0]    pressed, rise;
    logic [1:0]    pend_q, pend_d;
    logic          rr_q, rr_d;        // player favoured on the next tie
    logic [1:0]    press_q, press_d;
    logic [1:0]    grant;
    logic [3:0]    score0_d, score1_d, score_inc;
    logic          winner_q, winner_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign pressed = {~sync1[1], ~sync0[1]};
    assign rise    = pressed & ~prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync0    <= 2'b11;
            sync1    <= 2'b11;
            prev     <= 2'b00;
            pend_q   <= 2'b00;
            rr_q     <= 1'b0;
            press_q  <= 2'b00;
            score0   <= 4'd0;
            score1   <= 4'd0;
            winner_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync0    <= {sync0[0], key0_n};
            sync1    <= {sync1[0], key1_n};
            prev     <= pressed;
            pend_q   <= pend_d;
            rr_q     <= rr_d;
            press_q  <= press_d;
            score0   <= score0_d;
            score1   <= score1_d;
            winner_q <= winner_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        rr_d      = rr_q;
        press_d   = 2'b00;
        grant     = 2'b00;
        score0_d  = score0;
        score1_d  = score1;
        winner_d  = winner_q;
        cnt_d     = cnt_q;
        score_inc = (win_player ? score1 : score0) + 4'd1;

        case (state_q)
            IDLE: begin
                score0_d = 4'd0;
                score1_d = 4'd0;
                winner_d = 1'b0;
                pend_d   = 2'b00;
                if (start) begin
                    state_d = PLAY;
                    rr_d    = 1'b0;
                end
            end
            PLAY: begin
                if (win_valid) begin
                    // A round win wins over any grant this cycle.
                    pend_d = 2'b00;
                    if (win_player) score1_d = score_inc;
                    else            score0_d = score_inc;
                    if (score_inc == WINS) begin
                        state_d  = OVER;
                        winner_d = win_player;
                    end else begin
                        state_d = PAUSE;
                        cnt_d   = PAUSE_LOAD;
                    end
                end else begin
                    if (&pend_q) begin
                        grant = rr_q ? 2'b10 : 2'b01;
                        rr_d  = ~rr_q;
                    end else begin
                        grant = pend_q;
                    end
                    press_d = grant;
                    // An edge arriving while already pending is dropped.
                    pend_d  = (pend_q & ~grant) | (~pend_q & rise);
                end
            end
            PAUSE: begin
                if (cnt_q == '0) state_d = PLAY;
                else             cnt_d   = cnt_q - CW'(1);
            end
            OVER: begin
                if (!start) begin
                    state_d  = IDLE;
                    score0_d = 4'd0;
                    score1_d = 4'd0;
                    winner_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign press0       = press_q[0];
    assign press1       = press_q[1];
    assign game_reset   = (state_q == IDLE) || (state_q == PAUSE);
    assign match_over   = (state_q == OVER);
    assign match_winner = winner_q;
    assign state        = state_q;

endmodule

// File: tb/tb_tow_match_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tow_match_ctrl
//   Directed scenarios followed by randomized keys/wins/start/reset, checked
//   every cycle against a behavioural model of the match rules.
// -----------------------------------------------------------------------------
module tb_tow_match_ctrl;

    localparam int WINS  = 3;
    localparam int PAUSE = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       key0_n = 1'b1, key1_n = 1'b1;
    logic       start = 1'b0, win_valid = 1'b0, win_player = 1'b0;
    logic       press0, press1, game_reset, match_over, match_winner;
    logic [3:0] score0, score1;
    logic [1:0] state;

    tow_match_ctrl #(.WINS_TO_MATCH(WINS), .PAUSE_CYCLES(PAUSE)) dut (
        .clk(clk), .reset(reset), .key0_n(key0_n), .key1_n(key1_n),
        .start(start), .win_valid(win_valid), .win_player(win_player),
        .press0(press0), .press1(press1), .game_reset(game_reset),
        .score0(score0), .score1(score1), .match_over(match_over),
        .match_winner(match_winner), .state(state)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 play, 2 pause, 3 over
    int       m_phase = 0;
    int       m_sc[2] = '{0, 0};
    bit       m_win   = 1'b0;
    bit [1:0] m_wait  = 2'b00;   // players with a press waiting for a grant
    bit       m_rr    = 1'b0;    // who wins the next tie
    int       m_pc    = 0;       // pause cycles elapsed
    bit [1:0] m_p     = 2'b00;   // expected press pulses
    logic [2:0] hk0 = 3'b111, hk1 = 3'b111;  // sampled raw keys, [0] newest
    bit [1:0] e, was;
    int       g;

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = 0; m_sc[0] = 0; m_sc[1] = 0; m_win = 0;
            m_wait = 0; m_rr = 0; m_pc = 0; m_p = 0;
            hk0 = 3'b111; hk1 = 3'b111;
        end else begin
            // a newly pressed key becomes visible two samples after its fall
            e[0] = !hk0[1] && hk0[2];
            e[1] = !hk1[1] && hk1[2];
            hk0  = {hk0[1:0], key0_n};
            hk1  = {hk1[1:0], key1_n};
            m_p  = 2'b00;
            case (m_phase)
                0: begin
                    m_sc[0] = 0; m_sc[1] = 0; m_win = 0; m_wait = 0;
                    if (start) begin m_phase = 1; m_rr = 0; end
                end
                1: begin
                    if (win_valid) begin
                        m_wait = 0;
                        m_sc[win_player] = m_sc[win_player] + 1;
                        if (m_sc[win_player] == WINS) begin
                            m_phase = 3; m_win = win_player;
                        end else begin
                            m_phase = 2; m_pc = 0;
                        end
                    end else begin
                        was = m_wait;
                        if (was == 2'b11) begin g = int'(m_rr); m_rr = !m_rr; end
                        else if (was[0])  g = 0;
                        else if (was[1])  g = 1;
                        else              g = -1;
                        if (g >= 0) begin m_p[g] = 1'b1; m_wait[g] = 1'b0; end
                        for (int i = 0; i < 2; i++)
                            if (e[i] && !was[i]) m_wait[i] = 1'b1;
                    end
                end
                2: begin
                    m_pc++;
                    if (m_pc == PAUSE) m_phase = 1;
                end
                default: begin
                    if (!start) begin
                        m_phase = 0; m_sc[0] = 0; m_sc[1] = 0; m_win = 0;
                    end
                end
            endcase
        end
    end

    // ---------------- per-cycle comparison ----------------
    int p0_cnt, p1_cnt, p0_first, p1_first, gr_cnt;
    bit gr_on = 1'b0;

    always @(negedge clk) begin
        #1;
        chk("press0",       press0,       m_p[0]);
        chk("press1",       press1,       m_p[1]);
        chk("game_reset",   game_reset,   (m_phase == 0 || m_phase == 2));
        chk("score0",       score0,       m_sc[0]);
        chk("score1",       score1,       m_sc[1]);
        chk("match_over",   match_over,   (m_phase == 3));
        chk("match_winner", match_winner, m_win);
        chk("state",        state,        m_phase);
        chk("one_hot_press", press0 & press1, 0);
        if (press0) begin p0_cnt++; if (p0_first < 0) p0_first = cyc; end
        if (press1) begin p1_cnt++; if (p1_first < 0) p1_first = cyc; end
        if (gr_on && game_reset) gr_cnt++;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clr_cnt();
        p0_cnt = 0; p1_cnt = 0; p0_first = -1; p1_first = -1;
    endtask

    task automatic do_win(input logic p);
        int n = 0;
        while (m_phase != 1 && n < 300) begin tick(); n++; end
        if (m_phase != 1) chk("wait_play_timeout", m_phase, 1);
        win_valid = 1'b1; win_player = p;
        tick();
        win_valid = 1'b0;
    endtask

    int k;

    initial begin
        clr_cnt();
        repeat (3) tick();
        chk("rst_state", state, 0);
        chk("rst_game_reset", game_reset, 1);
        chk("rst_scores", {score1, score0}, 0);

        // release and start
        reset = 1'b1; start = 1'b1;
        tick();
        chk("start_state", state, 1);
        chk("start_game_reset", game_reset, 0);

        // single held key: one pulse, fixed latency
        tick();
        clr_cnt();
        key0_n = 1'b0; k = cyc + 1;
        repeat (10) tick();
        key0_n = 1'b1;
        repeat (4) tick();
        chk("hold_p0_count", p0_cnt, 1);
        chk("hold_p0_latency", p0_first, k + 3);
        chk("hold_p1_count", p1_cnt, 0);

        // tie, pointer at player 0
        clr_cnt();
        key0_n = 1'b0; key1_n = 1'b0; k = cyc + 1;
        repeat (6) tick();
        key0_n = 1'b1; key1_n = 1'b1;
        repeat (4) tick();
        chk("tie1_p0_first", p0_first, k + 3);
        chk("tie1_p1_second", p1_first, k + 4);

        // repeated tie, pointer now at player 1
        clr_cnt();
        key0_n = 1'b0; key1_n = 1'b0; k = cyc + 1;
        repeat (6) tick();
        key0_n = 1'b1; key1_n = 1'b1;
        repeat (4) tick();
        chk("tie2_p1_first", p1_first, k + 3);
        chk("tie2_p0_second", p0_first, k + 4);

        // win collides with a pending grant
        clr_cnt();
        key1_n = 1'b0;
        repeat (3) tick();
        win_valid = 1'b1; win_player = 1'b1; gr_cnt = 0; gr_on = 1'b1;
        tick();
        win_valid = 1'b0; key1_n = 1'b1;
        chk("collide_score1", score1, 1);
        chk("collide_state", state, 2);
        repeat (100) tick();
        gr_on = 1'b0;
        chk("collide_no_press", p0_cnt + p1_cnt, 0);
        chk("pause_len", gr_cnt, PAUSE);
        chk("pause_back_play", state, 1);

        // player 0 takes the match
        do_win(1'b0); do_win(1'b0); do_win(1'b0);
        tick();
        chk("over_flag", match_over, 1);
        chk("over_winner", match_winner, 0);
        chk("over_scores", {score1, score0}, {4'd1, 4'd3});
        clr_cnt();
        win_valid = 1'b1; win_player = 1'b1; key0_n = 1'b0;
        repeat (3) tick();
        win_valid = 1'b0;
        repeat (5) tick();
        key0_n = 1'b1;
        tick();
        chk("over_frozen_score1", score1, 1);
        chk("over_no_press", p0_cnt + p1_cnt, 0);
        start = 1'b0;
        repeat (2) tick();
        chk("idle_state", state, 0);
        chk("idle_scores", {score1, score0}, 0);
        chk("idle_over_clear", match_over, 0);

        // reset in the middle of a pause
        start = 1'b1;
        do_win(1'b0); do_win(1'b0);
        repeat (5) tick();
        chk("pre_abort_score0", score0, 2);
        reset = 1'b0;
        #1;
        chk("abort_state", state, 0);
        chk("abort_game_reset", game_reset, 1);
        chk("abort_score0", score0, 0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk("restart_state", state, 1);
        chk("restart_scores", {score1, score0}, 0);

        // randomized play
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(3) == 0)   key0_n = ~key0_n;
            if ($urandom_range(3) == 0)   key1_n = ~key1_n;
            win_valid  = ($urandom_range(29) == 0);
            win_player = 1'($urandom_range(1));
            if ($urandom_range(59) == 0)  start = ~start;
            if ($urandom_range(799) == 0) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
